bus_write_ctrl: RTL
===================

# bus_write_ctrl

Destination side of the processor's shared 17-bit data bus. Each cycle it decodes a 4-bit write-enable code and loads the bus value into one datapath register. Codes match the source-select encoding used on the bus read side, so one microinstruction performs a single-cycle register-to-register transfer. The block also issues data-memory writes through a req/ack handshake, and increments PC and AR.

## Interface
Parameters:
- N, 17, bus width
- W, 12, datapath register width (W ≤ N)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- write_en  in  4  destination select code (decoded below)
- busin  in  N  shared bus value
- inc_pc  in  1  increment PC this cycle
- inc_ar  in  1  increment AR this cycle
- dm_wr_ack  in  1  data memory accepted write
- ar, pc, r, ir, ac, r1, r2, r3, r4  out  W each  registered datapath registers
- dm_addr  out  W  captured write address
- dm_wdata  out  W  captured write data
- dm_wr_req  out  1  memory write request
- busy  out  1  DM write in flight
- wr_overrun  out  1  sticky: DM write requested while busy

## Operation
- Decode of write_en, sampled each rising edge:
  - 1: AR
  - 2: PC
  - 3: R
  - 4: IR
  - 5: AC
  - 7: R1
  - 8: R2
  - 9: R3
  - 10: R4
  - 12: DM write
  - All other codes: no-op.
- Width rule: destination registers load busin[W-1:0]; busin[N-1:W] is ignored.
- Increments: inc_pc sets PC ← PC+1 and inc_ar sets AR ← AR+1, both modulo 2^W (12'hFFF → 12'h000).
- Same-register conflict: a bus write to PC (code 2) or AR (code 1) overrides a simultaneous inc on that register.
- DM write FSM has two states:
  - IDLE: on write_en=12, capture dm_wdata ← busin[W-1:0] and dm_addr ← current AR (the pre-edge value, even if AR is also written or incremented that edge), then go to REQ.
  - REQ: dm_wr_req=1 and busy=1. When dm_wr_ack is sampled 1, go to IDLE.
- While in REQ:
  - dm_addr and dm_wdata stay stable.
  - write_en=12 is dropped (no capture, no queuing) and sets wr_overrun=1.
  - All other register writes and increments proceed normally.
- dm_wr_ack sampled in IDLE is ignored.
- wr_overrun is cleared only by rst.

## Timing
- Reset values: every output is 0, including all registers, dm_addr, dm_wdata, dm_wr_req, busy and wr_overrun. FSM resets to IDLE.
- Register write latency: write_en and busin are sampled at edge k; the new value is visible after edge k. This allows a combinational bus read followed by this write to complete in one cycle.
- DM handshake:
  - write_en=12 at edge k → dm_wr_req=1 and busy=1 after edge k.
  - dm_wr_ack=1 sampled at edge m>k → dm_wr_req=0 and busy=0 after edge m.
  - Minimum request width is 1 cycle, which occurs when ack is already high at edge k+1.
- Back-to-back: a new write_en=12 is accepted at the same edge where ack retires the previous request only if the FSM is IDLE at that edge. In practice the earliest accept is the edge after the one where ack is sampled; a code-12 at the ack edge itself is an overrun.
- Reset mid-handshake: rst at edge k forces dm_wr_req=0 and FSM to IDLE after edge k. The transaction is abandoned, and a late ack is ignored.
- rst has priority over every write, increment and FSM event.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then load: assert rst 2 cycles, then drive write_en=7 with busin=17'h1ABCD → r1=12'hBCD after the edge; all other outputs remain 0.
- Sweep all 16 codes with busin=17'h00555 → only the decoded register becomes 12'h555 each time; codes 0, 6, 11, 13, 14, 15 change nothing.
- Increment wrap and conflict:
  - Load PC=12'hFFF, then inc_pc=1 → PC=12'h000.
  - Next cycle, inc_pc=1 together with write_en=2 and busin=17'h00123 → PC=12'h123 (write wins).
- DM write with AR race:
  - Set AR=12'h040.
  - Issue write_en=12 with busin=17'h00777, plus inc_ar=1, on the same edge → dm_addr=12'h040, dm_wdata=12'h777, dm_wr_req=1, AR=12'h041.
  - Hold ack low 3 cycles → req stays 1 and data stays stable.
  - Ack 1 cycle → req=0 and busy=0 on the next edge.
- Overrun:
  - While in REQ, issue write_en=12 with busin=17'h00999 → dm_wdata stays at the old value and wr_overrun=1.
  - wr_overrun stays 1 after the ack and clears only on rst.
- Reset in REQ: assert rst while dm_wr_req=1 → req=0 and busy=0 after the edge. A following ack does nothing, and a fresh write_en=12 is accepted normally.

Source files
------------

// File: rtl/bus_write_ctrl.sv
// Bus destination side: decodes write_en to load one datapath register from the
// shared bus, increments PC/AR, and issues data-memory writes via req/ack.
module bus_write_ctrl #(
  parameter int unsigned N = 17,
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   write_en,
  input  logic [N-1:0] busin,
  input  logic         inc_pc,
  input  logic         inc_ar,
  input  logic         dm_wr_ack,
  output logic [W-1:0] ar,
  output logic [W-1:0] pc,
  output logic [W-1:0] r,
  output logic [W-1:0] ir,
  output logic [W-1:0] ac,
  output logic [W-1:0] r1,
  output logic [W-1:0] r2,
  output logic [W-1:0] r3,
  output logic [W-1:0] r4,
  output logic [W-1:0] dm_addr,
  output logic [W-1:0] dm_wdata,
  output logic         dm_wr_req,
  output logic         busy,
  output logic         wr_overrun
);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  localparam logic [3:0] C_AR = 4'd1,  C_PC = 4'd2,  C_R  = 4'd3,  C_IR = 4'd4,
                         C_AC = 4'd5,  C_R1 = 4'd7,  C_R2 = 4'd8,  C_R3 = 4'd9,
                         C_R4 = 4'd10, C_DM = 4'd12;

  state_t       r_state;
  logic [W-1:0] r_ar, r_pc, r_r, r_ir, r_ac, r_r1, r_r2, r_r3, r_r4;
  logic [W-1:0] r_dm_addr, r_dm_wdata;
  logic         r_dm_wr_req, r_busy, r_wr_overrun;
  logic [W-1:0] w_bus;
  logic         w_unused_hi;

  assign w_bus       = busin[W-1:0];
  assign w_unused_hi = ^busin[N-1:W];

  // Datapath registers; a bus write to PC/AR takes priority over its increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar <= '0; r_pc <= '0; r_r  <= '0; r_ir <= '0; r_ac <= '0;
      r_r1 <= '0; r_r2 <= '0; r_r3 <= '0; r_r4 <= '0;
    end else begin
      if (write_en == C_AR)  r_ar <= w_bus;
      else if (inc_ar)       r_ar <= r_ar + 1'b1;
      if (write_en == C_PC)  r_pc <= w_bus;
      else if (inc_pc)       r_pc <= r_pc + 1'b1;
      case (write_en)
        C_R:     r_r  <= w_bus;
        C_IR:    r_ir <= w_bus;
        C_AC:    r_ac <= w_bus;
        C_R1:    r_r1 <= w_bus;
        C_R2:    r_r2 <= w_bus;
        C_R3:    r_r3 <= w_bus;
        C_R4:    r_r4 <= w_bus;
        default: ;
      endcase
    end
  end

  // DM write handshake; address is the pre-edge AR, so it sees r_ar before update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dm_addr    <= '0;
      r_dm_wdata   <= '0;
      r_dm_wr_req  <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_overrun <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (write_en == C_DM) begin
            r_dm_addr   <= r_ar;
            r_dm_wdata  <= w_bus;
            r_dm_wr_req <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (write_en == C_DM) r_wr_overrun <= 1'b1;
          if (dm_wr_ack) begin
            r_dm_wr_req <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ar = r_ar;  assign pc = r_pc;  assign r  = r_r;   assign ir = r_ir;
  assign ac = r_ac;  assign r1 = r_r1;  assign r2 = r_r2;  assign r3 = r_r3;
  assign r4 = r_r4;
  assign dm_addr    = r_dm_addr;
  assign dm_wdata   = r_dm_wdata;
  assign dm_wr_req  = r_dm_wr_req;
  assign busy       = r_busy;
  assign wr_overrun = r_wr_overrun;

endmodule
